// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join sequencer family: join modes, response codes
// and the controller state encoding.
package fork_join_pkg;

    localparam int N_TASK_DEFAULT = 4;
    localparam int WDOG_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_EMPTY   = 2'd2
    } rsp_status_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        ABORT  = 3'd3,
        RESP   = 3'd4
    } state_e;

    // The reserved encoding 3 behaves as JOIN_ALL.
    function automatic join_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return JOIN_ANY;
            2'd2:    return JOIN_NONE;
            default: return JOIN_ALL;
        endcase
    endfunction

endpackage

// File: rtl/fj_watchdog.sv
// Loadable down-counter watchdog. A load value of 0 leaves it disarmed; expire
// flags the enabled cycle on which the counter reads 1.
module fj_watchdog #(
    parameter int WDOG_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WDOG_W-1:0] load_val,
    input  logic              enable,
    output logic              expire
);

    logic [WDOG_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = enable && (count_q == WDOG_W'(1));

endmodule

// File: rtl/fork_join_sequencer.sv
// Fork/join controller: one command forks a set of task engines, joins them in
// ALL/ANY/NONE mode with an optional watchdog, and returns one response.
module fork_join_sequencer
    import fork_join_pkg::*;
#(
    parameter int N_TASK = N_TASK_DEFAULT,
    parameter int WDOG_W = WDOG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [N_TASK-1:0] cmd_mask,
    input  logic [1:0]        cmd_mode,
    input  logic [WDOG_W-1:0] cmd_wdog,
    output logic [N_TASK-1:0] task_start,
    input  logic [N_TASK-1:0] task_done,
    output logic [N_TASK-1:0] task_abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [N_TASK-1:0] rsp_done_mask,
    output logic              busy,
    output state_e            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and once raised the payload holds
    // until that transfer.

    state_e            state_q, state_d;
    join_mode_e        mode_q, mode_d;
    logic [N_TASK-1:0] pending_q, pending_d;
    logic [N_TASK-1:0] outstanding_q, outstanding_d;
    logic [N_TASK-1:0] done_acc_q, done_acc_d;
    logic [N_TASK-1:0] start_q, start_d;
    logic [N_TASK-1:0] abort_q, abort_d;
    logic [N_TASK-1:0] rsp_mask_q, rsp_mask_d;
    rsp_status_e       rsp_status_q, rsp_status_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              out_of_reset_q;

    logic              accept;
    logic              wd_enable;
    logic              wd_expire;
    logic [N_TASK-1:0] hit;
    logic [N_TASK-1:0] pend_left;
    logic [N_TASK-1:0] launch_guard;
    logic              complete;

    // out_of_reset_q keeps cmd_ready low while reset is held.
    assign cmd_ready = out_of_reset_q && (state_q == IDLE) &&
                       ((cmd_mask & outstanding_q) == '0);
    assign accept    = cmd_valid && cmd_ready;
    assign wd_enable = (state_q == WAIT);

    assign hit          = task_done & pending_q;
    assign pend_left    = pending_q & ~task_done;
    // Tasks just launched cannot finish in their start cycle.
    assign launch_guard = (state_q == LAUNCH) ? pending_q : '0;
    assign complete     = (mode_q == JOIN_ANY) ? (hit != '0)
                                               : ((hit != '0) && (pend_left == '0));

    fj_watchdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (cmd_wdog),
        .enable   (wd_enable),
        .expire   (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        pending_d     = pending_q;
        done_acc_d    = done_acc_q;
        start_d       = '0;
        abort_d       = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_mask_d    = rsp_mask_q;
        outstanding_d = outstanding_q & ~(task_done & ~launch_guard);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d     = decode_mode(cmd_mode);
                    done_acc_d = '0;
                    if (cmd_mask == '0) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_EMPTY;
                        rsp_mask_d   = '0;
                    end else begin
                        state_d       = LAUNCH;
                        start_d       = cmd_mask;
                        pending_d     = cmd_mask;
                        outstanding_d = outstanding_d | cmd_mask;
                    end
                end
            end

            LAUNCH: begin
                if (mode_q == JOIN_NONE) begin
                    // Fire-and-forget: tasks stay outstanding until they report.
                    state_d      = RESP;
                    pending_d    = '0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_mask_d   = '0;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                done_acc_d = done_acc_q | hit;
                pending_d  = pend_left;
                if (complete && (mode_q == JOIN_ANY)) begin
                    state_d       = ABORT;
                    abort_d       = pend_left;
                    outstanding_d = outstanding_d & ~pend_left;
                    pending_d     = '0;
                    rsp_status_d  = ST_OK;
                end else if (complete) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_mask_d   = done_acc_q | hit;
                end else if (wd_expire) begin
                    state_d       = ABORT;
                    abort_d       = pend_left;
                    outstanding_d = outstanding_d & ~pend_left;
                    pending_d     = '0;
                    rsp_status_d  = ST_TIMEOUT;
                end
            end

            ABORT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_mask_d  = done_acc_q;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d      = IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_status_d = ST_OK;
                    rsp_mask_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= JOIN_ALL;
            pending_q      <= '0;
            outstanding_q  <= '0;
            done_acc_q     <= '0;
            start_q        <= '0;
            abort_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= ST_OK;
            rsp_mask_q     <= '0;
            out_of_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            pending_q      <= pending_d;
            outstanding_q  <= outstanding_d;
            done_acc_q     <= done_acc_d;
            start_q        <= start_d;
            abort_q        <= abort_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_status_q   <= rsp_status_d;
            rsp_mask_q     <= rsp_mask_d;
            out_of_reset_q <= 1'b1;
        end
    end

    assign task_start    = start_q;
    assign task_abort    = abort_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_done_mask = rsp_mask_q;
    assign busy          = (state_q != IDLE) || (outstanding_q != '0);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fork_join_sequencer.sv
// Scoreboard bench for fork_join_sequencer: directed scenarios plus random
// commands, each response predicted from the join rules by a timing model.
module tb_fork_join_sequencer;
  import fork_join_pkg::*;

  localparam int N  = 4;
  localparam int WW = 16;
  localparam int XW = 22;  // {latency[7:0], starts, aborts, done_mask, status}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [N-1:0]  cmd_mask = '0;
  logic [1:0]    cmd_mode = '0;
  logic [WW-1:0] cmd_wdog = '0;
  logic [N-1:0]  task_start;
  logic [N-1:0]  task_done = '0;
  logic [N-1:0]  task_abort;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [N-1:0]  rsp_done_mask;
  logic          busy;
  state_e        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [XW-1:0] exp_q[$];

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  fork_join_sequencer #(.N_TASK(N), .WDOG_W(WW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mask      (cmd_mask),
    .cmd_mode      (cmd_mode),
    .cmd_wdog      (cmd_wdog),
    .task_start    (task_start),
    .task_done     (task_done),
    .task_abort    (task_abort),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_status    (rsp_status),
    .rsp_done_mask (rsp_done_mask),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [4*5-1:0] mk(input int d0, input int d1, input int d2, input int d3);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  // Reference: done_dly[i] is the cycle offset from the accept cycle at which
  // task i reports. Samples count from offset 2; with a watchdog w, offsets up
  // to w+1 still count, later ones are cut off by the abort.
  function automatic logic [XW-1:0] model(input logic [3:0] mask, input logic [1:0] mode,
                                          input logic [15:0] wdog, input logic [19:0] dly);
    int lat, limit, last, first, d;
    logic [3:0] dn, ab;
    logic [1:0] st;
    dn = '0; ab = '0; st = 2'd0; lat = 0;
    if (mask == '0) begin
      lat = 1; st = 2'd2;
    end else if (mode == 2'd2) begin
      lat = 2;
    end else begin
      limit = (wdog == 0) ? 1000 : int'(wdog) + 1;
      last = 0; first = 1000;
      for (int i = 0; i < 4; i++) begin
        d = int'(dly[i*5 +: 5]);
        if (mask[i] && d > last) last = d;
        if (mask[i] && d < first) first = d;
      end
      if (mode == 2'd1) begin
        if (first <= limit) begin
          for (int i = 0; i < 4; i++) if (mask[i] && int'(dly[i*5 +: 5]) == first) dn[i] = 1'b1;
          ab = mask & ~dn; lat = first + 2;
        end else begin
          st = 2'd1; ab = mask; lat = int'(wdog) + 3;
        end
      end else begin
        if (last <= limit) begin
          dn = mask; lat = last + 1;
        end else begin
          for (int i = 0; i < 4; i++) if (mask[i] && int'(dly[i*5 +: 5]) <= limit) dn[i] = 1'b1;
          st = 2'd1; ab = mask & ~dn; lat = int'(wdog) + 3;
        end
      end
    end
    return {8'(lat), mask, ab, dn, st};
  endfunction

  // ---------------- monitor / scoreboard
  int cyc = 0;
  int t_acc = -1;
  int abort_cyc = 0;
  logic [3:0] start_acc = '0, abort_acc = '0, prev_dm = '0;
  logic [1:0] prev_st = '0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [XW-1:0] got, expv;

  always @(negedge clk) begin
    if (!rst_n) begin
      t_acc = -1; start_acc = '0; abort_acc = '0; prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      cyc++;
      if (cmd_valid && cmd_ready) begin
        t_acc = cyc; start_acc = '0; abort_acc = '0;
      end
      if (task_start != '0) begin
        start_acc |= task_start;
        check("start_cycle", cyc, t_acc + 1);
      end
      if (task_start != '0 || task_abort != '0) check("start_abort_excl", task_start & task_abort, 0);
      if (task_abort != '0) begin
        abort_acc |= task_abort; abort_cyc = cyc;
      end
      if (rsp_valid && !prev_valid) begin
        got = {8'(cyc - t_acc), start_acc, abort_acc, rsp_done_mask, rsp_status};
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", got, 0);
        end else begin
          expv = exp_q.pop_front();
          check("rsp{lat,start,abort,done,status}", got, expv);
        end
        if (abort_acc != '0) check("abort_cycle", abort_cyc, cyc - 1);
      end
      if (prev_valid && !prev_ready) check("rsp_hold", {rsp_valid, rsp_status, rsp_done_mask}, {1'b1, prev_st, prev_dm});
      if (rsp_valid) check("ready_in_resp", cmd_ready, 0);
      prev_valid = rsp_valid; prev_ready = rsp_ready; prev_st = rsp_status; prev_dm = rsp_done_mask;
    end
  end

  // ---------------- driver tasks (inputs change at posedge + 1)
  task automatic send_cmd(input logic [3:0] mask, input logic [1:0] mode, input logic [15:0] wdog,
                          input logic [3:0] rel_done, input int rel_after, output int stalls);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mask = mask; cmd_mode = mode; cmd_wdog = wdog;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      stalls++;
      if (stalls > 100) begin
        check("cmd_accept_timeout", stalls, 0);
        break;
      end
      @(posedge clk); #1;
      task_done = (stalls == rel_after) ? rel_done : '0;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; task_done = '0;
  endtask

  task automatic run_loop(input logic [3:0] mask, input logic [19:0] dly,
                          input logic [3:0] junk1, input logic [3:0] junk3, input int hold);
    int hcnt;
    logic hs;
    logic [3:0] d;
    hcnt = 0;
    for (int k = 1; k <= 80; k++) begin
      d = '0;
      for (int i = 0; i < 4; i++) if (mask[i] && int'(dly[i*5 +: 5]) == k) d[i] = 1'b1;
      if (k == 1) d |= junk1;
      if (k == 3) d |= junk3 & ~mask;
      task_done = d;
      if (rsp_valid) begin
        if (hcnt >= hold) rsp_ready = 1'b1;
        else hcnt++;
      end
      @(negedge clk);
      hs = rsp_valid && rsp_ready;
      @(posedge clk); #1;
      task_done = '0; rsp_ready = 1'b0;
      if (hs) return;
    end
    check("rsp_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [3:0] mask, input logic [1:0] mode, input logic [15:0] wdog,
                         input logic [19:0] dly, input logic [3:0] junk1, input logic [3:0] junk3,
                         input int hold, input bit cleanup);
    int st;
    exp_q.push_back(model(mask, mode, wdog, dly));
    send_cmd(mask, mode, wdog, 4'b0000, -1, st);
    run_loop(mask, dly, junk1, junk3, hold);
    if (cleanup && mode == 2'd2 && mask != '0) begin
      task_done = mask;
      @(posedge clk); #1;
      task_done = '0;
    end
    if (cleanup || mode != 2'd2 || mask == '0) begin
      @(negedge clk);
      check("busy_after_cmd", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus
  initial begin
    int st;
    logic [3:0] m;
    logic [1:0] md;
    logic [15:0] w;
    logic [19:0] dl;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {cmd_ready, task_start, task_abort, rsp_valid, rsp_status, rsp_done_mask, busy}, 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // JOIN_ALL, staggered dones
    run_cmd(4'b1011, 2'd0, 16'd0, mk(3, 5, 31, 9), 4'b0000, 4'b0000, 0, 1);
    // JOIN_ANY, first done aborts the rest
    run_cmd(4'b0110, 2'd1, 16'd0, mk(31, 10, 4, 31), 4'b0000, 4'b0000, 0, 1);
    // JOIN_ALL timeout with one straggler
    run_cmd(4'b0011, 2'd0, 16'd5, mk(3, 31, 31, 31), 4'b0000, 4'b0000, 0, 1);
    // empty mask
    run_cmd(4'b0000, 2'd0, 16'd0, mk(31, 31, 31, 31), 4'b0000, 4'b0000, 0, 1);
    // completion coincides with watchdog expiry
    run_cmd(4'b0010, 2'd0, 16'd3, mk(31, 4, 31, 31), 4'b0000, 4'b0000, 0, 1);
    // reserved mode acts as JOIN_ALL
    run_cmd(4'b0101, 2'd3, 16'd0, mk(2, 31, 6, 31), 4'b0000, 4'b0000, 0, 1);

    // JOIN_NONE, then a disjoint and an overlapping follow-up
    exp_q.push_back(model(4'b0001, 2'd2, 16'd0, mk(31, 31, 31, 31)));
    send_cmd(4'b0001, 2'd2, 16'd0, 4'b0000, -1, st);
    run_loop(4'b0001, mk(31, 31, 31, 31), 4'b0000, 4'b0000, 0);
    exp_q.push_back(model(4'b0010, 2'd2, 16'd0, mk(31, 31, 31, 31)));
    send_cmd(4'b0010, 2'd2, 16'd0, 4'b0000, -1, st);
    check("no_stall_disjoint", st, 0);
    run_loop(4'b0010, mk(31, 31, 31, 31), 4'b0000, 4'b0000, 0);
    exp_q.push_back(model(4'b0001, 2'd0, 16'd0, mk(3, 31, 31, 31)));
    send_cmd(4'b0001, 2'd0, 16'd0, 4'b0001, 4, st);
    check("stall_overlap", st, 5);
    run_loop(4'b0001, mk(3, 31, 31, 31), 4'b0000, 4'b0000, 0);
    @(negedge clk);
    check("busy_outstanding", busy, 1);
    @(posedge clk); #1;
    task_done = 4'b0010;
    @(posedge clk); #1;
    task_done = '0;
    @(negedge clk);
    check("busy_cleared", busy, 0);
    @(posedge clk); #1;

    // long response back-pressure
    run_cmd(4'b1100, 2'd0, 16'd0, mk(31, 31, 3, 4), 4'b0000, 4'b0000, 7, 1);

    // asynchronous reset in the middle of WAIT
    send_cmd(4'b0101, 2'd0, 16'd0, 4'b0000, -1, st);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {cmd_ready, task_start, task_abort, rsp_valid, rsp_status, rsp_done_mask, busy}, 0);
    check("async_reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {task_abort, rsp_valid, busy}, 0);
    end
    @(posedge clk); #1;

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      m  = 4'($urandom_range(0, 15));
      md = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 16));
      for (int i = 0; i < 4; i++)
        dl[i*5 +: 5] = (w != 0 && $urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(2, 20));
      run_cmd(m, md, w, dl, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), 1);
    end

    repeat (3) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
